// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited sequential PC requests, an in-order
// response FIFO feeding the decoder, and redirect handling that squashes stale responses.

module fetch_unit_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outst,
    input logic [CW-1:0] squash,
    input logic          push,
    input logic          pop,
    input logic          imem_valid
);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    a_outst_bound: assert property (@(posedge clk) disable iff (rst)
        {1'b0, outst} <= DEPTH_W);
    a_squash_bound: assert property (@(posedge clk) disable iff (rst)
        squash <= outst);
    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        ({1'b0, count} + {1'b0, outst} - {1'b0, squash}) <= DEPTH_W);
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && ({1'b0, count} == DEPTH_W)));
    a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
        !(imem_valid && (outst == {CW{1'b0}})));
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc_r, fetch_pc_s;
    logic [31:0]   resp_pc_r, resp_pc_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [CW-1:0] count_r, count_s;
    logic [CW-1:0] outst_r, outst_s;
    logic [CW-1:0] squash_r, squash_s;
    logic [31:0]   pc_mem_r  [DEPTH];
    logic [31:0]   ins_mem_r [DEPTH];

    logic [31:0]   redirect_pc_s;
    logic [CW:0]   credit_s;
    logic          req_s, fire_s, head_valid_s, pop_s, push_s, drop_s, wr_en_s;
    logic [CW-1:0] fire_inc_s, resp_dec_s, push_inc_s, pop_dec_s, drop_dec_s;

    // Credit accounting and per-cycle handshake decode.
    always_comb begin
        redirect_pc_s = i_redirect_pc & 32'hFFFF_FFFC;
        // Squashed responses still occupy an outstanding slot but never reach the FIFO.
        credit_s      = {1'b0, count_r} + {1'b0, outst_r} - {1'b0, squash_r};
        req_s         = !rst && !i_redirect && (credit_s < DEPTH_W);
        fire_s        = req_s && i_imem_ready;
        head_valid_s  = (count_r != {CW{1'b0}});
        pop_s         = head_valid_s && i_ready;
        drop_s        = i_imem_valid && (squash_r != {CW{1'b0}});
        push_s        = i_imem_valid && (squash_r == {CW{1'b0}});
        wr_en_s       = push_s && !i_redirect && !rst;
        fire_inc_s    = {{(CW-1){1'b0}}, fire_s};
        resp_dec_s    = {{(CW-1){1'b0}}, i_imem_valid};
        push_inc_s    = {{(CW-1){1'b0}}, push_s};
        pop_dec_s     = {{(CW-1){1'b0}}, pop_s};
        drop_dec_s    = {{(CW-1){1'b0}}, drop_s};
    end

    // Next-state computation; a redirect overrides every other event in the cycle.
    always_comb begin
        fetch_pc_s = fetch_pc_r;
        resp_pc_s  = resp_pc_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        outst_s    = outst_r;
        squash_s   = squash_r;
        if (i_redirect) begin
            fetch_pc_s = redirect_pc_s;
            resp_pc_s  = redirect_pc_s;
            wr_ptr_s   = {AW{1'b0}};
            rd_ptr_s   = {AW{1'b0}};
            count_s    = {CW{1'b0}};
            outst_s    = outst_r - resp_dec_s;
            squash_s   = outst_r - resp_dec_s;
        end else begin
            fetch_pc_s = fire_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            resp_pc_s  = push_s ? (resp_pc_r + 32'd4) : resp_pc_r;
            wr_ptr_s   = push_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
            rd_ptr_s   = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;
            count_s    = count_r + push_inc_s - pop_dec_s;
            outst_s    = outst_r + fire_inc_s - resp_dec_s;
            squash_s   = squash_r - drop_dec_s;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            outst_r    <= {CW{1'b0}};
            squash_r   <= {CW{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_s;
            resp_pc_r  <= resp_pc_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            outst_r    <= outst_s;
            squash_r   <= squash_s;
        end
    end

    // FIFO payload storage; contents are qualified by count_r so need no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pc_mem_r[wr_ptr_r]  <= resp_pc_r;
            ins_mem_r[wr_ptr_r] <= i_imem_rdata;
        end else begin
            pc_mem_r[wr_ptr_r]  <= pc_mem_r[wr_ptr_r];
            ins_mem_r[wr_ptr_r] <= ins_mem_r[wr_ptr_r];
        end
    end

    assign o_imem_req    = req_s;
    assign o_imem_addr   = fetch_pc_r;
    assign o_valid       = head_valid_s;
    assign o_pc          = pc_mem_r[rd_ptr_r];
    assign o_instruction = ins_mem_r[rd_ptr_r];

    fetch_unit_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
        .clk        (clk),
        .rst        (rst),
        .count      (count_r),
        .outst      (outst_r),
        .squash     (squash_r),
        .push       (wr_en_s),
        .pop        (pop_s),
        .imem_valid (i_imem_valid)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model of the fetch
// pipeline plus directed scenarios and a randomized run.

module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst, o_imem_req, i_imem_ready, i_imem_valid, i_redirect, o_valid, i_ready;
    logic [31:0] o_imem_addr, i_imem_rdata, i_redirect_pc, o_instruction, o_pc;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_valid  (i_imem_valid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_valid       (o_valid),
        .i_ready       (i_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } fent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    fent_t       fifo_q[$];
    mreq_t       mq[$];
    int          checks = 0, errors = 0, cyc = 0, lat = 1, m_squash = 0;
    logic [31:0] m_fetch_pc = RESET_PC, m_resp_pc = RESET_PC;
    bit          exp_req, exp_valid;
    logic [31:0] exp_addr, exp_pc, exp_ins;
    logic        obs_req, obs_valid, fired;
    logic [31:0] obs_addr, obs_pc, obs_ins;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC3C3_5A00;
    endfunction

    // One clock cycle: drive inputs, predict, sample outputs mid-cycle, advance model.
    task automatic step(input bit r, input bit redir, input logic [31:0] rpc,
                        input bit rdy, input bit mrdy);
        bit          resp;
        logic [31:0] raddr;
        fent_t       e;
        mreq_t       m;
        resp  = !r && (mq.size() > 0) && (mq[0].due <= cyc);
        raddr = resp ? mq[0].addr : 32'h0;
        rst = r; i_redirect = redir; i_redirect_pc = rpc; i_ready = rdy; i_imem_ready = mrdy;
        i_imem_valid = resp;
        i_imem_rdata = resp ? mem_data(raddr) : $urandom();
        exp_req   = !r && !redir && ((fifo_q.size() + mq.size() - m_squash) < DEPTH);
        exp_addr  = m_fetch_pc;
        exp_valid = fifo_q.size() > 0;
        exp_pc    = exp_valid ? fifo_q[0].pc : 32'h0;
        exp_ins   = exp_valid ? fifo_q[0].ins : 32'h0;
        #1;
        obs_req = o_imem_req; obs_addr = o_imem_addr; obs_valid = o_valid;
        obs_pc = o_pc; obs_ins = o_instruction;
        fired = o_imem_req && mrdy;
        if (r) begin
            fifo_q.delete(); mq.delete(); m_squash = 0;
            m_fetch_pc = RESET_PC; m_resp_pc = RESET_PC;
        end else if (redir) begin
            if (resp) void'(mq.pop_front());
            m_squash = mq.size();
            fifo_q.delete();
            m_fetch_pc = {rpc[31:2], 2'b00};
            m_resp_pc  = m_fetch_pc;
        end else begin
            if (exp_valid && rdy) void'(fifo_q.pop_front());
            if (resp) begin
                void'(mq.pop_front());
                if (m_squash > 0) m_squash--;
                else begin
                    e.pc = m_resp_pc; e.ins = mem_data(raddr);
                    fifo_q.push_back(e);
                    m_resp_pc += 32'd4;
                end
            end
            if (exp_req && mrdy) begin
                m.addr = m_fetch_pc; m.due = cyc + lat;
                mq.push_back(m);
                m_fetch_pc += 32'd4;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (obs_req !== 1'b0 || (i > 0 && obs_valid !== 1'b0)) begin
                errors++;
                $display("FAIL reset cyc=%0d got req=%b valid=%b expected req=0 valid=0", i, obs_req, obs_valid);
            end
        end
    endtask

    task automatic test_stream();
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                errors++;
                $display("FAIL stream_req i=%0d got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr);
            end
            checks++;
            if (i < 2 ? (obs_valid !== 1'b0)
                      : (obs_valid !== 1'b1 || obs_pc !== RESET_PC + 32'(4 * (i - 2))
                         || obs_ins !== mem_data(RESET_PC + 32'(4 * (i - 2))))) begin
                errors++;
                $display("FAIL stream_out i=%0d got valid=%b pc=%h ins=%h", i, obs_valid, obs_pc, obs_ins);
            end
        end
    endtask

    task automatic test_backpressure();
        int nfire = 0, ndel = 0;
        logic [31:0] nxt = RESET_PC;
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            if (fired) nfire++;
        end
        checks++;
        if (nfire != DEPTH || obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== RESET_PC) begin
            errors++;
            $display("FAIL bp_fill got fires=%0d req=%b valid=%b pc=%h expected fires=%0d req=0 valid=1 pc=%h", nfire, obs_req, obs_valid, obs_pc, DEPTH, RESET_PC);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (obs_valid !== exp_valid || (exp_valid && (obs_pc !== exp_pc || obs_ins !== exp_ins))
                || obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
                errors++;
                $display("FAIL bp_drain i=%0d got v=%b pc=%h req=%b addr=%h expected v=%b pc=%h req=%b addr=%h", i, obs_valid, obs_pc, obs_req, obs_addr, exp_valid, exp_pc, exp_req, exp_addr);
            end
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_pc !== nxt) begin
                    errors++;
                    $display("FAIL bp_order got pc=%h expected pc=%h", obs_pc, nxt);
                end
                nxt += 32'd4; ndel++;
            end
        end
        checks++;
        if (ndel < 8) begin
            errors++;
            $display("FAIL bp_count got deliveries=%0d expected at least 8", ndel);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] target;
        bit seen;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        lat = 4;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int s = 0; s < 2; s++) begin
            if (s == 0) begin
                target = 32'h100;
                step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
            end else begin
                target = 32'h508;
                step(1'b0, 1'b1, 32'h405, 1'b1, 1'b1);
                step(1'b0, 1'b1, 32'h50B, 1'b1, 1'b1);
            end
            checks++;
            if (obs_req !== 1'b0) begin
                errors++;
                $display("FAIL redir_noreq s=%0d got req=%b expected req=0", s, obs_req);
            end
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
                checks++;
                if (obs_valid !== exp_valid || (exp_valid && (obs_pc !== exp_pc || obs_ins !== exp_ins))
                    || (i == 0 && (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== target))) begin
                    errors++;
                    $display("FAIL redir_flow s=%0d i=%0d got v=%b pc=%h req=%b addr=%h target=%h", s, i, obs_valid, obs_pc, obs_req, obs_addr, target);
                end
                if (obs_valid === 1'b1) begin
                    seen = 1'b1;
                    checks++;
                    if (obs_pc !== target || obs_ins !== mem_data(target)) begin
                        errors++;
                        $display("FAIL redir_first s=%0d got pc=%h ins=%h expected pc=%h ins=%h", s, obs_pc, obs_ins, target, mem_data(target));
                    end
                end
            end
            if (!seen) begin
                checks++; errors++;
                $display("FAIL redir_timeout s=%0d no valid output within 20 cycles", s);
            end
        end
    endtask

    task automatic test_redirect_resp_pop();
        bit seen = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        lat = 2;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
        checks++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || i_imem_valid !== 1'b1) begin
            errors++;
            $display("FAIL rrp_setup got req=%b valid=%b resp=%b expected req=0 valid=1 resp=1", obs_req, obs_valid, i_imem_valid);
        end
        for (int i = 0; i < 12 && !seen; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if ((i == 0 && (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200))
                || obs_valid !== exp_valid || (exp_valid && (obs_pc !== exp_pc || obs_ins !== exp_ins))) begin
                errors++;
                $display("FAIL rrp_flow i=%0d got v=%b pc=%h req=%b addr=%h", i, obs_valid, obs_pc, obs_req, obs_addr);
            end
            if (obs_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (obs_pc !== 32'h200 || obs_ins !== mem_data(32'h200)) begin
                    errors++;
                    $display("FAIL rrp_first got pc=%h ins=%h expected pc=00000200 ins=%h", obs_pc, obs_ins, mem_data(32'h200));
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL rrp_timeout no valid output within 12 cycles");
        end
    endtask

    task automatic test_ready_toggle();
        logic [3:0] pat = 4'b1001;
        logic        prev_hold = 1'b0;
        logic [31:0] prev_addr = 32'h0, nxt = RESET_PC;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, pat[3 - (i % 4)]);
            checks++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)
                || (prev_hold && obs_req === 1'b1 && obs_addr !== prev_addr)) begin
                errors++;
                $display("FAIL toggle_req i=%0d got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr);
            end
            prev_hold = obs_req && !fired;
            prev_addr = obs_addr;
            if (obs_valid === 1'b1) begin
                checks++;
                if (obs_pc !== nxt || obs_ins !== mem_data(nxt)) begin
                    errors++;
                    $display("FAIL toggle_order got pc=%h ins=%h expected pc=%h", obs_pc, obs_ins, nxt);
                end
                nxt += 32'd4;
            end
        end
    endtask

    task automatic test_random();
        bit redir;
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            lat   = $urandom_range(1, 4);
            redir = ($urandom_range(0, 9) == 0);
            step(1'b0, redir, $urandom(), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            checks++;
            if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)
                || obs_valid !== exp_valid || (exp_valid && (obs_pc !== exp_pc || obs_ins !== exp_ins))) begin
                errors++;
                $display("FAIL random i=%0d got req=%b addr=%h v=%b pc=%h ins=%h expected req=%b addr=%h v=%b pc=%h ins=%h", i, obs_req, obs_addr, obs_valid, obs_pc, obs_ins, exp_req, exp_addr, exp_valid, exp_pc, exp_ins);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        lat = 1;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_full got valid=%b req=%b expected valid=1 req=0", obs_valid, obs_req);
        end
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (obs_req !== 1'b0) begin
            errors++;
            $display("FAIL midrst_req got req=%b expected req=0", obs_req);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midrst_restart got valid=%b req=%b addr=%h expected valid=0 req=1 addr=%h", obs_valid, obs_req, obs_addr, RESET_PC);
        end
    endtask

    initial begin
        rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_ready = 1'b0;
        i_imem_ready = 1'b0; i_imem_valid = 1'b0; i_imem_rdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_resp_pop();
        test_ready_toggle();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Front-end fetch stage that generates sequential PCs, issues requests to the instruction memory and buffers returned instructions in a small FIFO. It drives the decoder's instruction/PC/valid inputs and honours the decoder's ready backpressure. It also accepts a redirect from the back end, which flushes every in-flight and buffered instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
DEPTH, 4, instruction FIFO entries; also the maximum outstanding requests (power of two, >= 2).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
o_imem_req  output  1  instruction memory request valid.
o_imem_addr  output  32  request address (the fetch PC, word aligned).
i_imem_ready  input  1  memory accepts the request this cycle.
i_imem_valid  input  1  response valid; responses return in order, latency >= 1 cycle.
i_imem_rdata  input  32  response instruction word.
i_redirect  input  1  flush and restart fetch.
i_redirect_pc  input  32  new fetch PC (bits [1:0] are ignored and treated as 0).
o_instruction  output  32  instruction to the decoder (FIFO head).
o_pc  output  32  PC of o_instruction.
o_valid  output  1  FIFO head is valid.
i_ready  input  1  decoder accepts the head this cycle.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - fetch_pc = RESET_PC; resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; squash = 0.
  - o_valid = 0; o_imem_req = 0.
  - Reset mid-operation drops everything. Responses to pre-reset requests arriving after reset are the environment's responsibility and are not required to be handled.
- Credit rule:
  - o_imem_req = !rst && !i_redirect && (fifo_count + outstanding - squash) < DEPTH.
  - o_imem_addr = fetch_pc.
  - Handshake fires on o_imem_req && i_imem_ready: fetch_pc += 4, outstanding += 1.
  - o_imem_req and o_imem_addr are combinational from registered state and i_redirect. They may drop without a handshake.
- Response, i_imem_valid=1:
  - outstanding -= 1.
  - If squash > 0: squash -= 1 and the data is discarded.
  - Otherwise push {resp_pc, i_imem_rdata} into the FIFO and resp_pc += 4.
  - The credit rule guarantees the FIFO is never pushed while full.
- Decoder handshake:
  - o_valid = FIFO not empty; o_instruction/o_pc = head entry.
  - Pop on o_valid && i_ready.
  - Head stays stable while o_valid && !i_ready.
- Simultaneous push and pop: both take effect and fifo_count is unchanged. A pop from a full FIFO plus a push in the same cycle is legal.
- Redirect (i_redirect=1), effective at that edge; it has priority over everything else in the cycle:
  - FIFO cleared, so o_valid=0 in the next cycle. A pop in the same cycle is ignored.
  - No request issued this cycle.
  - fetch_pc = resp_pc = {i_redirect_pc[31:2],2'b00}.
  - squash = outstanding after this cycle's response is counted. Equivalently, squash_next = outstanding - (i_imem_valid ? 1 : 0), and a response arriving in the redirect cycle is discarded.
  - First request at the new PC is issued the cycle after the redirect.
  - Back-to-back redirects: the last one wins, and the squash count accumulates correctly.
- Latency: an instruction appears on o_valid one cycle after its response (registered FIFO).
  - With a 1-cycle memory and i_ready=1, the first o_valid is 2 cycles after reset deassertion.
  - Throughput is then 1 instruction per cycle.
- Widths and wrap:
  - fifo_count, outstanding and squash are $clog2(DEPTH)+1 bits.
  - FIFO pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - PC arithmetic wraps modulo 2^32.
- Invariants (for assertions):
  - outstanding <= DEPTH.
  - squash <= outstanding.
  - fifo_count + outstanding - squash <= DEPTH.
  - No push when full.
  - No i_imem_valid while outstanding == 0 (environment error).

Test Plan:
- Reset release, 1-cycle memory returning addr as data, i_ready=1 -> o_imem_addr 0,4,8,...; o_valid from cycle 2 with o_pc=0,4,8 and o_instruction=o_pc, one per cycle, no gaps.
- i_ready=0 from reset, DEPTH=4 -> exactly 4 requests (0,4,8,C), o_imem_req then stays 0; head holds o_pc=0. Raising i_ready drains 0,4,8,C while new fetch resumes at 0x10 with no skipped or duplicated PC.
- 3-cycle memory, 3 requests outstanding, redirect to 0x100 -> the 3 stale responses are dropped; the next o_valid has o_pc=0x100 with its data; FIFO is empty in the cycle after the redirect.
- Redirect to 0x203 in the same cycle as a response and a pop -> response discarded, pop ignored, next fetch address 0x200, squash = outstanding-1.
- i_imem_ready toggling 1,0,0,1 -> o_imem_addr held while not ready; PCs delivered in order with no duplicates.
- rst asserted mid-stream with a full FIFO -> next cycle o_valid=0 and o_imem_req=0; after release, fetch restarts at RESET_PC.
